// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES shared types, S-box and xtime helpers for key schedule and encipher core
package aes_pkg;

    localparam logic KEY128 = 1'b0;
    localparam logic KEY256 = 1'b1;

    localparam int NR128_DEFAULT = 10;
    localparam int NR256_DEFAULT = 14;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_GEN  = 1'b1;

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// rtl/aes_key_expand_if.sv - key-schedule control and round-key read bundle
interface aes_key_expand_if;
    logic         init;
    logic         keylen;
    logic [255:0] key;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic         ready;

    modport master (output init, keylen, key, round_idx, input round_key, ready);
    modport slave  (input init, keylen, key, round_idx, output round_key, ready);
endinterface

// File: rtl/aes_sbox_word.sv
// rtl/aes_sbox_word.sv - 32-bit SubWord built from four byte S-box lookups
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] subst
);

    assign subst = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - AES round-key expansion into a readable file; AES-256 via AES_KEY256_EN
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR128 = NR128_DEFAULT,
    parameter int NR256 = NR256_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_key_expand_if.slave bus
);

`ifdef AES_KEY256_EN
    localparam int NUM_KEYS = NR256 + 1;
`else
    localparam int NUM_KEYS = NR128 + 1;
`endif

    state_t       state;
    logic [3:0]   cnt;
    logic [7:0]   rcon;
    logic         ready_q;
    logic [127:0] rk [NUM_KEYS];
    logic         keylen_q;

`ifndef AES_KEY256_EN
    // Without AES-256 support the schedule is permanently 128-bit.
    logic unused_bits;
    assign keylen_q    = KEY128;
    assign unused_bits = ^{bus.key[127:0], bus.keylen};
`endif

    logic [3:0]   active_nr;
    logic [3:0]   idx_m1, idx_m2;
    logic [127:0] prev1, prev2, base, new_key, rd_data;
    logic [31:0]  last, sbox_in, sub, t;
    logic [31:0]  w0, w1, w2, w3;
    logic         odd256;

    assign active_nr = (keylen_q == KEY256) ? 4'(NR256) : 4'(NR128);
    assign idx_m1    = cnt - 4'd1;
    assign idx_m2    = cnt - 4'd2;

    always_comb begin
        prev1   = '0;
        prev2   = '0;
        rd_data = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (4'(i) == idx_m1) prev1 = rk[i];
            if (4'(i) == idx_m2) prev2 = rk[i];
            if (4'(i) == bus.round_idx && bus.round_idx <= active_nr) rd_data = rk[i];
        end
    end

    // Odd AES-256 rounds skip RotWord and Rcon; everything else is the classic step.
    assign odd256  = (keylen_q == KEY256) && cnt[0];
    assign base    = (keylen_q == KEY256) ? prev2 : prev1;
    assign last    = prev1[31:0];
    assign sbox_in = odd256 ? last : {last[23:0], last[31:24]};

    aes_sbox_word u_sbox_word (
        .word  (sbox_in),
        .subst (sub)
    );

    assign t       = odd256 ? sub : (sub ^ {rcon, 24'h000000});
    assign w0      = base[127:96] ^ t;
    assign w1      = base[95:64]  ^ w0;
    assign w2      = base[63:32]  ^ w1;
    assign w3      = base[31:0]   ^ w2;
    assign new_key = {w0, w1, w2, w3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rcon    <= 8'h01;
            ready_q <= 1'b0;
`ifdef AES_KEY256_EN
            keylen_q <= KEY128;
`endif
            for (int i = 0; i < NUM_KEYS; i++) rk[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.init) begin
                        ready_q <= 1'b0;
                        rcon    <= 8'h01;
                        rk[0]   <= bus.key[255:128];
                        state   <= ST_GEN;
`ifdef AES_KEY256_EN
                        keylen_q <= bus.keylen;
                        if (bus.keylen == KEY256) begin
                            rk[1] <= bus.key[127:0];
                            cnt   <= 4'd2;
                        end else begin
                            cnt   <= 4'd1;
                        end
`else
                        cnt <= 4'd1;
`endif
                    end
                end
                default: begin
                    for (int i = 0; i < NUM_KEYS; i++) begin
                        if (4'(i) == cnt) rk[i] <= new_key;
                    end
                    if (keylen_q == KEY128 || !cnt[0]) rcon <= xtime(rcon);
                    if (cnt == active_nr) begin
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.round_key = rd_data;
    assign bus.ready     = ready_q;

endmodule
